// File: rtl/fft_bin_streamer.sv
// Snapshots one frame of FFT bins and streams them out one per beat with
// arithmetic shift, saturation and index tag. FFT_BITREV_EN: read bins in bit-reversed order.
//
// state  | meaning
// IDLE   | in_ready high, waiting for in_valid to capture a frame
// STREAM | presenting beats on out_*, advancing on out_valid && out_ready
module fft_bin_streamer #(
    parameter int N     = 16,
    parameter int LOGN  = 4,
    parameter int INW   = 48,
    parameter int OUTW  = 16,
    parameter int SHIFT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*INW-1:0]    yr_flat,
    input  logic [N*INW-1:0]    yi_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUTW-1:0]     out_re,
    output logic [OUTW-1:0]     out_im,
    output logic [LOGN-1:0]     out_idx,
    output logic                out_last,
    output logic                out_sat,
    output logic                frame_sat
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic signed [INW-1:0] SAT_MAX = {{(INW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [INW-1:0] SAT_MIN = {{(INW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

    state_t          state;
    logic [LOGN-1:0] cnt;
    logic [INW-1:0]  snap_re [N];
    logic [INW-1:0]  snap_im [N];

    function automatic logic [LOGN-1:0] bin_of(input logic [LOGN-1:0] c);
        logic [LOGN-1:0] r;
`ifdef FFT_BITREV_EN
        for (int i = 0; i < LOGN; i++) r[i] = c[LOGN-1-i];
`else
        r = c;
`endif
        return r;
    endfunction

    // returns {saturated, value}
    function automatic logic [OUTW:0] scale(input logic [INW-1:0] x);
        logic signed [INW-1:0] s;
        logic [OUTW:0]         r;
        s = $signed(x) >>> SHIFT;
        if (s > SAT_MAX)      r = {1'b1, SAT_MAX[OUTW-1:0]};
        else if (s < SAT_MIN) r = {1'b1, SAT_MIN[OUTW-1:0]};
        else                  r = {1'b0, s[OUTW-1:0]};
        return r;
    endfunction

    logic [LOGN-1:0] bin_first;
    logic [LOGN-1:0] cnt_nxt;
    logic [LOGN-1:0] bin_nxt;
    logic [OUTW:0]   cap_re;
    logic [OUTW:0]   cap_im;
    logic [OUTW:0]   nxt_re;
    logic [OUTW:0]   nxt_im;

    // first beat comes straight from the inputs since the snapshot loads on the same edge
    always_comb begin
        bin_first = bin_of('0);
        cnt_nxt   = cnt + 1'b1;
        bin_nxt   = bin_of(cnt_nxt);
        cap_re    = scale(yr_flat[bin_first*INW +: INW]);
        cap_im    = scale(yi_flat[bin_first*INW +: INW]);
        nxt_re    = scale(snap_re[bin_nxt]);
        nxt_im    = scale(snap_im[bin_nxt]);
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            for (int k = 0; k < N; k++) begin
                snap_re[k] <= yr_flat[k*INW +: INW];
                snap_im[k] <= yi_flat[k*INW +: INW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
            frame_sat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= STREAM;
                        cnt       <= '0;
                        frame_sat <= 1'b0;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_re    <= cap_re[OUTW-1:0];
                        out_im    <= cap_im[OUTW-1:0];
                        out_sat   <= cap_re[OUTW] | cap_im[OUTW];
                        out_idx   <= bin_first;
                        out_last  <= (N == 1);
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        frame_sat <= frame_sat | out_sat;
                        cnt       <= cnt_nxt;
                        if (out_last) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_re    <= '0;
                            out_im    <= '0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                            out_sat   <= 1'b0;
                        end else begin
                            out_re    <= nxt_re[OUTW-1:0];
                            out_im    <= nxt_im[OUTW-1:0];
                            out_sat   <= nxt_re[OUTW] | nxt_im[OUTW];
                            out_idx   <= bin_nxt;
                            out_last  <= (cnt_nxt == LOGN'(N-1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Directed bench for fft_bin_streamer (N=16, INW=48, OUTW=16, SHIFT=8) with an expected-beat queue.
module tb_fft_bin_streamer;

    localparam int N = 16;
    localparam int INW = 48;
    localparam int OUTW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*INW-1:0]  yr_flat = '0;
    logic [N*INW-1:0]  yi_flat = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUTW-1:0]   out_re;
    logic [OUTW-1:0]   out_im;
    logic [3:0]        out_idx;
    logic              out_last;
    logic              out_sat;
    logic              frame_sat;

    fft_bin_streamer #(.N(N), .LOGN(4), .INW(INW), .OUTW(OUTW), .SHIFT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .yr_flat(yr_flat), .yi_flat(yi_flat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .out_last(out_last), .out_sat(out_sat), .frame_sat(frame_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [3:0]  idx;
        logic        last;
        logic        sat;
    } beat_t;

    beat_t             q[$];
    logic signed [47:0] fr [N];
    logic signed [47:0] fi [N];
    logic              fsat_exp;
    int                total = 0;
    int                bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] brev(input logic [3:0] c);
`ifdef FFT_BITREV_EN
        return {c[0], c[1], c[2], c[3]};
`else
        return c;
`endif
    endfunction

    // {sat, value} of (x >>> 8) clipped to 16 bits
    function automatic logic [16:0] model(input logic signed [47:0] x);
        longint s;
        s = longint'(x) >>> 8;
        if (s > 32767)       return {1'b1, 16'h7fff};
        else if (s < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, s[15:0]};
    endfunction

    task automatic load_and_push();
        beat_t      b;
        logic [3:0] bi;
        logic [16:0] mr, mi;
        for (int k = 0; k < N; k++) begin
            yr_flat[k*INW +: INW] = fr[k];
            yi_flat[k*INW +: INW] = fi[k];
        end
        q.delete();
        fsat_exp = 1'b0;
        for (int c = 0; c < N; c++) begin
            bi = brev(4'(c));
            mr = model(fr[bi]);
            mi = model(fi[bi]);
            b.re = mr[15:0];
            b.im = mi[15:0];
            b.idx = bi;
            b.last = (c == N-1);
            b.sat = mr[16] | mi[16];
            fsat_exp = fsat_exp | b.sat;
            q.push_back(b);
        end
    endtask

    task automatic start_frame();
        load_and_push();
        chk("idle_in_ready", in_ready, 1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // pat 0: always ready; pat 1: ready 1,0,0 repeating. abort_after>=0 stops after that many beats.
    task automatic stream(input int pat, input int abort_after, input bit recap);
        int    beats = 0;
        int    cyc = 0;
        bit    done = 0;
        beat_t e;
        while (!done && cyc < 200) begin
            out_ready = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
            if (recap && beats == 3) begin
                in_valid = 1'b1;
                yr_flat = ~yr_flat;
                yi_flat = ~yi_flat;
            end else begin
                in_valid = 1'b0;
            end
            if (cyc == 0) chk("first_frame_sat", frame_sat, 0);
            chk("valid", out_valid, 1);
            chk("in_ready_stream", in_ready, 0);
            if (q.size() == 0) begin
                chk("q_size", 64'(q.size()), 1);
                done = 1;
            end else begin
                e = q[0];
                chk("re", out_re, e.re);
                chk("im", out_im, e.im);
                chk("idx", out_idx, e.idx);
                chk("last", out_last, e.last);
                chk("sat", out_sat, e.sat);
                if (out_valid && out_ready) begin
                    void'(q.pop_front());
                    beats++;
                    if (beats == N || beats == abort_after) done = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (abort_after >= 0) begin
            chk("abort_beats", 64'(beats), 64'(abort_after));
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_valid", out_valid, 0);
            chk("abort_in_ready", in_ready, 1);
            chk("abort_frame_sat", frame_sat, 0);
            q.delete();
        end else begin
            chk("beats", 64'(beats), 16);
            chk("end_valid", out_valid, 0);
            chk("end_in_ready", in_ready, 1);
            chk("end_last", out_last, 0);
            chk("end_frame_sat", frame_sat, fsat_exp);
        end
    endtask

    initial begin
        int acc;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_re", out_re, 0);
        chk("rst_im", out_im, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_frame_sat", frame_sat, 0);

        // natural stream: re=k*1000, im=-k*1000 after the shift
        for (int k = 0; k < N; k++) begin
            fr[k] = 48'(k * 1000 * 256);
            fi[k] = -48'(k * 1000 * 256);
        end
        start_frame();
        stream(0, -1, 0);

        // backpressure
        start_frame();
        stream(1, -1, 0);

        // scaling and saturation
        for (int k = 0; k < N; k++) begin
            fr[k] = 48'(k);
            fi[k] = 48'(k * 300);
        end
        fr[3] = 48'(256000);
        fi[3] = -48'(2560);
        fr[4] = 48'(1) <<< 30;
        fi[5] = -(48'(1) <<< 30);
        fr[6] = -48'(1);
        fi[7] = 48'(32767 * 256 + 255);
        fr[8] = -48'(32768 * 256);
        start_frame();
        stream(0, -1, 0);

        // ramp through the FFT: bin 0 is the DC sum 100*(0+..+15)
        acc = 0;
        for (int i = 0; i < N; i++) acc += 100 * i;
        for (int k = 0; k < N; k++) begin
            fr[k] = '0;
            fi[k] = '0;
        end
        fr[0] = 48'(acc * 256);
        start_frame();
        stream(1, -1, 0);

        // bin k re=k: order check (natural or bit-reversed)
        for (int k = 0; k < N; k++) begin
            fr[k] = 48'(k * 256);
            fi[k] = -48'(k * 512);
        end
        start_frame();
        stream(0, -1, 1);

        // reset abort after beat 5, then a fresh frame from beat 0
        start_frame();
        stream(0, 6, 0);
        start_frame();
        stream(1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
